// File: rtl/buffer_rr_arbiter.sv
// Round-robin arbiter sitting behind N buffer_slots instances: grants one buffer per
// cycle via its stall line and forwards the granted beat on one registered channel.
module buffer_rr_arbiter #(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic                        sink_stall,
    input  logic [N_PORTS-1:0]          buf_req,
    input  logic [N_PORTS-1:0]          buf_valid,
    input  logic [N_PORTS*DATA_W-1:0]   buf_data,
    output logic [N_PORTS-1:0]          buf_stall,
    output logic                        buf_flush,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(N_PORTS)-1:0]  out_src,
    output logic [CNT_W-1:0]            beat_cnt,
    output logic [CNT_W-1:0]            bubble_cnt
);
    localparam int PTR_W = $clog2(N_PORTS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   scan_idx;
    logic [PTR_W-1:0]   rr_next;
    logic               req_found;
    logic               grant_any;
    logic [N_PORTS-1:0] grant_onehot;
    logic [N_PORTS-1:0] grant_q;

    logic [PTR_W-1:0]   cap_idx;
    logic               cap_any;
    logic               cap_valid;
    logic [DATA_W-1:0]  cap_data;

    // Stage A: rotating-priority scan starting at rr_ptr
    always_comb begin
        req_found = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            if (int'(rr_ptr) + k >= N_PORTS)
                scan_idx = PTR_W'(int'(rr_ptr) + k - N_PORTS);
            else
                scan_idx = PTR_W'(int'(rr_ptr) + k);
            if (!req_found && buf_req[scan_idx]) begin
                req_found = 1'b1;
                grant_idx = scan_idx;
            end
        end
        grant_any    = req_found && !flush && !sink_stall;
        grant_onehot = grant_any ? ({{(N_PORTS-1){1'b0}}, 1'b1} << grant_idx) : '0;
        rr_next      = (grant_idx == PTR_W'(N_PORTS - 1)) ? '0 : grant_idx + 1'b1;
    end

    assign buf_stall = reset ? '1 : ~grant_onehot;
    assign buf_flush = flush;

    // Stage B: pick the port granted last cycle
    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant_q[i]) cap_idx = PTR_W'(i);
        end
        cap_any   = |grant_q;
        cap_valid = buf_valid[cap_idx];
        cap_data  = buf_data[int'(cap_idx)*DATA_W +: DATA_W];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr     <= '0;
            grant_q    <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_src    <= '0;
            beat_cnt   <= '0;
            bubble_cnt <= '0;
        end else if (flush) begin
            rr_ptr    <= '0;
            grant_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            grant_q <= grant_onehot;
            if (grant_any) rr_ptr <= rr_next;
            if (cap_any && cap_valid) begin
                out_valid <= 1'b1;
                out_data  <= cap_data;
                out_src   <= cap_idx;
                beat_cnt  <= sat_inc(beat_cnt);
            end else begin
                out_valid <= 1'b0;
                if (cap_any) bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

endmodule
